sc_ulpi_urd: RTL and testbench
==============================

SC_ULPI_URD -- requirements
Module: sc_ulpi_urd

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
 - ULPICLK  in  1  sole clock, all logic rising-edge.
 - ULPIRSTB  in  1  reset, asynchronous, active-low.
 - RXD_CMD_VALID  in  1  ULPI_DATA holds an RX CMD byte this cycle.
 - RXD_DATA_VALID  in  1  ULPI_DATA holds a received USB byte this cycle.
 - ULPI_DATA  in  8  byte from the ULPI protocol engine; RX CMD [5:4]=RxEvent.
 - PKT_RX_DAT_VALID  out  1  payload byte strobe.
 - PKT_RX_DAT  out  8  payload byte (PID and CRC16 excluded).
 - PKT_RX_DONE  out  1  one-cycle end-of-packet pulse; status below valid with it.
 - PKT_RX_PID  out  4  received PID[3:0].
 - PKT_RX_LEN  out  11  payload byte count.
 - PKT_RX_PIDERR  out  1  PID check nibble mismatch.
 - PKT_RX_CRCERR  out  1  CRC16 residual mismatch.
 - PKT_RX_FMTERR  out  1  length illegal for PID class.
 - PKT_RX_RXERR  out  1  RxError seen during packet.

Function
REQ-002 SHALL decode RxEvent: 01 = RxActive; 11 = RxError (active); 00 and 10 = not active.
REQ-003 SHALL use states IDLE, PID, DATA, ERR.
REQ-004 IDLE -> PID on RX CMD with RxActive; data bytes in IDLE SHALL be ignored.
REQ-005 PID: first data byte latched into PKT_RX_PID; PIDERR = (byte[7:4] != ~byte[3:0]); -> DATA.
REQ-006 DATA: each byte SHALL update CRC16 (poly 0x8005, init 0xFFFF, LSB-first) and enter a 2-byte holding pipe; the byte pushed out of the pipe SHALL be emitted on PKT_RX_DAT with PKT_RX_DAT_VALID, one cycle after the push, and LEN SHALL increment.
REQ-007 RX CMD not active in PID or DATA SHALL end the packet: PKT_RX_DONE asserted the next cycle, pipe contents (CRC bytes) discarded, -> IDLE.
REQ-008 RX CMD RxError in PID or DATA SHALL set RXERR and -> ERR; ERR ignores data bytes and ends the packet per REQ-007 on not-active.
REQ-009 Handshake PIDs (ACK 0x2, NAK 0xA, STALL 0xE, NYET 0x6) SHALL have 0 bytes after PID, else FMTERR; data PIDs (0x3, 0xB, 0x7, 0xF) SHALL have >=2 bytes after PID, else FMTERR; other PIDs FMTERR.
REQ-010 CRCERR SHALL be evaluated only for data PIDs with >=2 bytes; residual SHALL equal 0x800D, else CRCERR=1.
REQ-011 LEN SHALL saturate at 2047.
REQ-012 Simultaneous RXD_CMD_VALID and RXD_DATA_VALID: the data byte SHALL take priority and the CMD SHALL be ignored.
REQ-013 Status outputs SHALL hold from PKT_RX_DONE until the next PID byte; error flags SHALL clear on entry to PID.
REQ-014 RX CMD with RxActive in PID or DATA (repeat) SHALL be ignored.

Reset
REQ-015 ULPIRSTB low SHALL asynchronously force IDLE, clear the pipe, LEN and CRC, and drive every output to 0.
REQ-016 Reset mid-packet SHALL produce no PKT_RX_DONE; the next packet SHALL decode normally.

Configuration
REQ-017 With SC_ULPI_URD_BABBLE_EN defined, a packet exceeding 1026 bytes after PID SHALL set FMTERR, stop payload emission, and -> ERR.
REQ-018 Without SC_ULPI_URD_BABBLE_EN, there SHALL be no length limit other than REQ-011.

Structure
REQ-019 Package sc_ulpi_pkg SHALL hold the PID constants, RxEvent encodings, CRC16 polynomial/init/residual, and the state enum.
REQ-020 CRC16 register and byte update SHALL be a sub-module sc_ulpi_crc16 (clear, enable, byte in, crc out).

Verification
REQ-021 CMD 0x10, data 0xD2, CMD 0x00 -> DONE, PID=0x2, LEN=0, all errors 0, no DAT_VALID.
REQ-022 CMD 0x10, data 0xC3 0x00 0x00, CMD 0x00 -> DONE, PID=0x3, LEN=0, CRCERR=0.
REQ-023 CMD 0x10, data 0x4B 0xA1 0xA2 0xA3 0x00 0x00, CMD 0x00 -> DAT A1, A2, A3, LEN=3, CRCERR=1.
REQ-024 CMD 0x10, data 0xD3, CMD 0x00 -> PIDERR=1, FMTERR=1.
REQ-025 CMD 0x10, data 0xC3 0x11, CMD 0x30, data 0x22, CMD 0x00 -> RXERR=1, DONE once, 0x22 not emitted.
REQ-026 Reset pulse after 0xC3 0x55, then the REQ-021 stimulus -> single DONE, PID=0x2, all errors 0.

Source files
------------

// File: rtl/sc_ulpi_pkg.sv
// -----------------------------------------------------------------------------
// sc_ulpi_pkg
// Shared definitions for the ULPI USB receive-packet decoder (sc_ulpi_urd):
//   - USB PID[3:0] constants (handshake and data classes)
//   - ULPI RX CMD RxEvent encodings (RX CMD bits [5:4])
//   - CRC16 polynomial, initial value and good-packet residual
//   - decoder state enum
//   - helper functions: RxEvent decode, PID classing, CRC16 byte update
// No ports (package).
// -----------------------------------------------------------------------------
package sc_ulpi_pkg;

   // Handshake PIDs
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;
   localparam logic [3:0] PID_NYET  = 4'h6;

   // Data PIDs
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_DATA2 = 4'h7;
   localparam logic [3:0] PID_MDATA = 4'hF;

   // RxEvent field of an RX CMD byte
   localparam logic [1:0] RXEV_INACTIVE = 2'b00;
   localparam logic [1:0] RXEV_ACTIVE   = 2'b01;
   localparam logic [1:0] RXEV_HOSTDISC = 2'b10;
   localparam logic [1:0] RXEV_ERROR    = 2'b11;

   // CRC16 as used by USB: data shifted in LSB-first, register MSB-first
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   // Byte counts
   localparam logic [10:0] LEN_MAX      = 11'd2047;
   localparam logic [10:0] BABBLE_LIMIT = 11'd1026;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PID  = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } urd_state_e;

   // RxActive and RxError both mean the line is active.
   function automatic logic rx_event_active(input logic [1:0] ev);
      return (ev == RXEV_ACTIVE) || (ev == RXEV_ERROR);
   endfunction

   function automatic logic rx_event_error(input logic [1:0] ev);
      return (ev == RXEV_ERROR);
   endfunction

   function automatic logic is_handshake_pid(input logic [3:0] pid);
      return (pid == PID_ACK) || (pid == PID_NAK) ||
             (pid == PID_STALL) || (pid == PID_NYET);
   endfunction

   function automatic logic is_data_pid(input logic [3:0] pid);
      return (pid == PID_DATA0) || (pid == PID_DATA1) ||
             (pid == PID_DATA2) || (pid == PID_MDATA);
   endfunction

   // One byte of CRC16, bit 0 of the byte enters first.
   function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                input logic [7:0]  din);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[15] ^ din[i];
         c  = {c[14:0], 1'b0};
         if (fb) begin
            c = c ^ CRC16_POLY;
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/sc_ulpi_crc16.sv
// -----------------------------------------------------------------------------
// sc_ulpi_crc16
// CRC16 accumulator for received USB bytes.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (register -> init value)
//   clr    in   reload init value
//   en     in   fold din into the CRC (ignored while clr is high)
//   din    in   8-bit byte
//   crc    out  16-bit CRC register
// -----------------------------------------------------------------------------
module sc_ulpi_crc16
   import sc_ulpi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   logic [15:0] crc_r;

   // CRC register: reload on clear, fold in one byte per enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_r <= CRC16_INIT;
      end else if (clr) begin
         crc_r <= CRC16_INIT;
      end else if (en) begin
         crc_r <= crc16_update(crc_r, din);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/sc_ulpi_urd.sv
// -----------------------------------------------------------------------------
// sc_ulpi_urd
// ULPI receive-packet decoder. Follows RX CMD RxEvent to frame a packet,
// latches and checks the PID, strips the trailing CRC16 with a two-byte
// holding pipe, streams the payload and reports status on end of packet.
//
// Optional feature (compile-time macro SC_ULPI_URD_BABBLE_EN):
//   when defined, more than 1026 bytes after the PID flags FMTERR, stops
//   payload emission and drops the rest of the packet.
//
// Ports:
//   ULPICLK           in   clock, rising edge
//   ULPIRSTB          in   asynchronous active-low reset
//   RXD_CMD_VALID     in   ULPI_DATA is an RX CMD byte
//   RXD_DATA_VALID    in   ULPI_DATA is a received byte (wins over CMD)
//   ULPI_DATA[7:0]    in   byte from the ULPI engine, RX CMD [5:4]=RxEvent
//   PKT_RX_DAT_VALID  out  payload byte strobe
//   PKT_RX_DAT[7:0]   out  payload byte (no PID, no CRC16)
//   PKT_RX_DONE       out  one-cycle end-of-packet pulse
//   PKT_RX_PID[3:0]   out  received PID[3:0]
//   PKT_RX_LEN[10:0]  out  payload byte count (saturates at 2047)
//   PKT_RX_PIDERR     out  PID check nibble mismatch
//   PKT_RX_CRCERR     out  CRC16 residual mismatch
//   PKT_RX_FMTERR     out  length illegal for PID class
//   PKT_RX_RXERR      out  RxError seen during packet
// -----------------------------------------------------------------------------
module sc_ulpi_urd
   import sc_ulpi_pkg::*;
(
   input  logic        ULPICLK,
   input  logic        ULPIRSTB,
   input  logic        RXD_CMD_VALID,
   input  logic        RXD_DATA_VALID,
   input  logic [7:0]  ULPI_DATA,
   output logic        PKT_RX_DAT_VALID,
   output logic [7:0]  PKT_RX_DAT,
   output logic        PKT_RX_DONE,
   output logic [3:0]  PKT_RX_PID,
   output logic [10:0] PKT_RX_LEN,
   output logic        PKT_RX_PIDERR,
   output logic        PKT_RX_CRCERR,
   output logic        PKT_RX_FMTERR,
   output logic        PKT_RX_RXERR
);

   urd_state_e  state_r, state_nxt_s;

   logic        data_in_s, cmd_in_s, cmd_act_s, cmd_err_s, cmd_end_s;
   logic        babble_s;
   logic        start_s, pid_byte_s, byte_s, babble_hit_s, rxerr_s, end_s;
   logic        fmt_bad_s, crc_bad_s;
   logic [15:0] crc_s;

   logic [7:0]  pipe0_r, pipe1_r;      // pipe0 newest, pipe1 oldest
   logic [1:0]  pipe_cnt_r;
   logic [10:0] cnt_r;                 // bytes after PID, saturating
   logic        pid_seen_r;
   logic        dat_valid_r, done_r;
   logic [7:0]  dat_r;
   logic [3:0]  pid_r;
   logic [10:0] len_r;
   logic        piderr_r, crcerr_r, fmterr_r, rxerr_r;

   // A data byte takes priority, so a simultaneous CMD is dropped.
   assign data_in_s = RXD_DATA_VALID;
   assign cmd_in_s  = RXD_CMD_VALID & ~RXD_DATA_VALID;
   assign cmd_act_s = cmd_in_s &  rx_event_active(ULPI_DATA[5:4]);
   assign cmd_err_s = cmd_in_s &  rx_event_error(ULPI_DATA[5:4]);
   assign cmd_end_s = cmd_in_s & ~rx_event_active(ULPI_DATA[5:4]);

`ifdef SC_ULPI_URD_BABBLE_EN
   assign babble_s = (cnt_r >= BABBLE_LIMIT);
`else
   assign babble_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
      if (!ULPIRSTB) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_act_s) state_nxt_s = ST_PID;
            else           state_nxt_s = ST_IDLE;
         end
         ST_PID: begin
            if (data_in_s)      state_nxt_s = ST_DATA;
            else if (cmd_err_s) state_nxt_s = ST_ERR;
            else if (cmd_end_s) state_nxt_s = ST_IDLE;
            else                state_nxt_s = ST_PID;
         end
         ST_DATA: begin
            if (data_in_s && babble_s) state_nxt_s = ST_ERR;
            else if (cmd_err_s)        state_nxt_s = ST_ERR;
            else if (cmd_end_s)        state_nxt_s = ST_IDLE;
            else                       state_nxt_s = ST_DATA;
         end
         ST_ERR: begin
            if (cmd_end_s) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_ERR;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Per-state control strobes for the datapath.
   always_comb begin
      start_s      = 1'b0;
      pid_byte_s   = 1'b0;
      byte_s       = 1'b0;
      babble_hit_s = 1'b0;
      rxerr_s      = 1'b0;
      end_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = cmd_act_s;
         end
         ST_PID: begin
            pid_byte_s = data_in_s;
            rxerr_s    = cmd_err_s;
            end_s      = cmd_end_s;
         end
         ST_DATA: begin
            byte_s       = data_in_s & ~babble_s;
            babble_hit_s = data_in_s &  babble_s;
            rxerr_s      = cmd_err_s;
            end_s        = cmd_end_s;
         end
         ST_ERR: begin
            end_s = cmd_end_s;
         end
         default: begin
            start_s = 1'b0;
         end
      endcase
   end

   // Length rule per PID class; ending before any PID byte is malformed.
   always_comb begin
      if (!pid_seen_r) begin
         fmt_bad_s = 1'b1;
      end else if (is_handshake_pid(pid_r)) begin
         fmt_bad_s = (cnt_r != 11'd0);
      end else if (is_data_pid(pid_r)) begin
         fmt_bad_s = (cnt_r < 11'd2);
      end else begin
         fmt_bad_s = 1'b1;
      end
   end

   assign crc_bad_s = pid_seen_r & is_data_pid(pid_r) & (cnt_r >= 11'd2) &
                      (crc_s != CRC16_RESIDUAL);

   sc_ulpi_crc16 u_crc16 (
      .clk   (ULPICLK),
      .rst_n (ULPIRSTB),
      .clr   (start_s),
      .en    (byte_s),
      .din   (ULPI_DATA),
      .crc   (crc_s)
   );

   // Datapath: holding pipe, counters, payload stream and status flags.
   always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
      if (!ULPIRSTB) begin
         pipe0_r     <= 8'h00;
         pipe1_r     <= 8'h00;
         pipe_cnt_r  <= 2'd0;
         cnt_r       <= 11'd0;
         pid_seen_r  <= 1'b0;
         dat_valid_r <= 1'b0;
         dat_r       <= 8'h00;
         done_r      <= 1'b0;
         pid_r       <= 4'h0;
         len_r       <= 11'd0;
         piderr_r    <= 1'b0;
         crcerr_r    <= 1'b0;
         fmterr_r    <= 1'b0;
         rxerr_r     <= 1'b0;
      end else begin
         dat_valid_r <= 1'b0;
         done_r      <= 1'b0;
         if (start_s) begin
            pipe_cnt_r <= 2'd0;
            cnt_r      <= 11'd0;
            pid_seen_r <= 1'b0;
            piderr_r   <= 1'b0;
            crcerr_r   <= 1'b0;
            fmterr_r   <= 1'b0;
            rxerr_r    <= 1'b0;
         end
         if (pid_byte_s) begin
            pid_r      <= ULPI_DATA[3:0];
            piderr_r   <= (ULPI_DATA[7:4] != ~ULPI_DATA[3:0]);
            len_r      <= 11'd0;
            pid_seen_r <= 1'b1;
         end
         if (byte_s) begin
            // The last two bytes of a packet are its CRC and never leave the pipe.
            pipe0_r <= ULPI_DATA;
            pipe1_r <= pipe0_r;
            if (cnt_r != LEN_MAX) begin
               cnt_r <= cnt_r + 11'd1;
            end
            if (pipe_cnt_r == 2'd2) begin
               dat_valid_r <= 1'b1;
               dat_r       <= pipe1_r;
               if (len_r != LEN_MAX) begin
                  len_r <= len_r + 11'd1;
               end
            end else begin
               pipe_cnt_r <= pipe_cnt_r + 2'd1;
            end
         end
         if (babble_hit_s) begin
            fmterr_r <= 1'b1;
         end
         if (rxerr_s) begin
            rxerr_r <= 1'b1;
         end
         if (end_s) begin
            done_r   <= 1'b1;
            fmterr_r <= fmterr_r | fmt_bad_s;
            crcerr_r <= crc_bad_s;
         end
      end
   end

   assign PKT_RX_DAT_VALID = dat_valid_r;
   assign PKT_RX_DAT       = dat_r;
   assign PKT_RX_DONE      = done_r;
   assign PKT_RX_PID       = pid_r;
   assign PKT_RX_LEN       = len_r;
   assign PKT_RX_PIDERR    = piderr_r;
   assign PKT_RX_CRCERR    = crcerr_r;
   assign PKT_RX_FMTERR    = fmterr_r;
   assign PKT_RX_RXERR     = rxerr_r;

endmodule

// File: tb/tb_sc_ulpi_urd.sv
// -----------------------------------------------------------------------------
// tb_sc_ulpi_urd
// Self-checking bench for sc_ulpi_urd: directed packets plus randomized
// packets, compared against a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_sc_ulpi_urd;

   logic        ULPICLK = 1'b0;
   logic        ULPIRSTB = 1'b0;
   logic        RXD_CMD_VALID = 1'b0;
   logic        RXD_DATA_VALID = 1'b0;
   logic [7:0]  ULPI_DATA = 8'h00;
   logic        PKT_RX_DAT_VALID;
   logic [7:0]  PKT_RX_DAT;
   logic        PKT_RX_DONE;
   logic [3:0]  PKT_RX_PID;
   logic [10:0] PKT_RX_LEN;
   logic        PKT_RX_PIDERR, PKT_RX_CRCERR, PKT_RX_FMTERR, PKT_RX_RXERR;

   sc_ulpi_urd dut (
      .ULPICLK          (ULPICLK),
      .ULPIRSTB         (ULPIRSTB),
      .RXD_CMD_VALID    (RXD_CMD_VALID),
      .RXD_DATA_VALID   (RXD_DATA_VALID),
      .ULPI_DATA        (ULPI_DATA),
      .PKT_RX_DAT_VALID (PKT_RX_DAT_VALID),
      .PKT_RX_DAT       (PKT_RX_DAT),
      .PKT_RX_DONE      (PKT_RX_DONE),
      .PKT_RX_PID       (PKT_RX_PID),
      .PKT_RX_LEN       (PKT_RX_LEN),
      .PKT_RX_PIDERR    (PKT_RX_PIDERR),
      .PKT_RX_CRCERR    (PKT_RX_CRCERR),
      .PKT_RX_FMTERR    (PKT_RX_FMTERR),
      .PKT_RX_RXERR     (PKT_RX_RXERR)
   );

   always #5 ULPICLK = ~ULPICLK;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [3:0]  pid;
      logic [10:0] len;
      logic        pe, ce, fe, re;
   } stat_t;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int dat_seen = 0;

   // Reference model state (packet level)
   logic [7:0]  exp_dat[$];
   stat_t       exp_done[$];
   byte_q_t     body;
   bit          in_pkt, have_pid, dropping;
   logic [3:0]  m_pid, prev_pid;
   logic [10:0] prev_len;
   bit          m_pe, m_fe, m_re;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Textbook reflected CRC-16/USB register (right-shifting, poly 0xA001).
   function automatic logic [15:0] crc_refl(input byte_q_t q);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) begin
         c = c ^ {8'h00, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [15:0] bitrev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15 - i];
      return r;
   endfunction

   task automatic model_reset();
      in_pkt = 0; have_pid = 0; dropping = 0;
      prev_pid = 4'h0; prev_len = 11'd0;
      m_pe = 0; m_fe = 0; m_re = 0;
      body.delete();
   endtask

   task automatic model_finish();
      stat_t s;
      int    n;
      bit    hs, dp;
      n = body.size();
      if (have_pid) begin
         hs    = (m_pid inside {4'h2, 4'hA, 4'hE, 4'h6});
         dp    = (m_pid inside {4'h3, 4'hB, 4'h7, 4'hF});
         s.pid = m_pid;
         s.len = (n < 2) ? 11'd0 : ((n - 2 > 2047) ? 11'd2047 : 11'(n - 2));
         s.fe  = m_fe | (hs ? (n != 0) : (dp ? (n < 2) : 1'b1));
         s.ce  = dp && (n >= 2) && (bitrev16(crc_refl(body)) != 16'h800D);
         s.pe  = m_pe;
      end else begin
         s.pid = prev_pid;
         s.len = prev_len;
         s.fe  = 1'b1;
         s.ce  = 1'b0;
         s.pe  = 1'b0;
      end
      s.re = m_re;
      exp_done.push_back(s);
      prev_pid = s.pid;
      prev_len = s.len;
      in_pkt = 0;
   endtask

   task automatic model_step(input logic c, input logic d, input logic [7:0] v);
      if (d) begin
         if (in_pkt && !dropping) begin
            if (!have_pid) begin
               have_pid = 1; m_pid = v[3:0]; m_pe = (v[7:4] != ~v[3:0]);
               body.delete();
            end else begin
`ifdef SC_ULPI_URD_BABBLE_EN
               if (body.size() >= 1026) begin
                  m_fe = 1; dropping = 1;
               end else
`endif
               begin
                  body.push_back(v);
                  // everything except the final two bytes is payload
                  if (body.size() >= 3) exp_dat.push_back(body[body.size() - 3]);
               end
            end
         end
      end else if (c) begin
         if (!in_pkt) begin
            if (v[5:4] == 2'b01 || v[5:4] == 2'b11) begin
               in_pkt = 1; have_pid = 0; dropping = 0;
               m_pe = 0; m_fe = 0; m_re = 0;
               body.delete();
            end
         end else if (v[5:4] == 2'b00 || v[5:4] == 2'b10) begin
            model_finish();
         end else if (v[5:4] == 2'b11 && !dropping) begin
            m_re = 1; dropping = 1;
         end
      end
   endtask

   task automatic beat(input logic c, input logic d, input logic [7:0] v);
      RXD_CMD_VALID = c; RXD_DATA_VALID = d; ULPI_DATA = v;
      model_step(c, d, v);
      @(posedge ULPICLK); #1;
      RXD_CMD_VALID = 1'b0; RXD_DATA_VALID = 1'b0; ULPI_DATA = 8'h00;
   endtask

   task automatic send_pkt(input logic [7:0] pidb, input int npay, input bit good,
                           input bit noise);
      byte_q_t     pay;
      logic [15:0] c;
      for (int i = 0; i < npay; i++) pay.push_back(8'($urandom));
      if (good) begin
         c = ~crc_refl(pay);
         pay.push_back(c[7:0]); pay.push_back(c[15:8]);
      end else begin
         pay.push_back(8'($urandom)); pay.push_back(8'($urandom));
      end
      beat(1'b1, 1'b0, (noise && $urandom_range(0, 5) == 0) ? 8'h30 : 8'h10);
      beat(1'b0, 1'b1, pidb);
      foreach (pay[i]) begin
         int r;
         r = noise ? $urandom_range(0, 7) : 7;
         if (r == 0) beat(1'b0, 1'b0, 8'h00);
         if (r == 1) beat(1'b1, 1'b0, 8'h10);
         if (r == 2) beat(1'b1, 1'b1, pay[i]);
         else        beat(1'b0, 1'b1, pay[i]);
      end
      if (noise && $urandom_range(0, 9) == 0) begin
         beat(1'b1, 1'b0, 8'h30);
         beat(1'b0, 1'b1, 8'($urandom));
      end
      beat(1'b1, 1'b0, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h20);
      beat(1'b0, 1'b0, 8'h00);
   endtask

   task automatic expect_status(input string tag, input logic [3:0] pid,
                                input logic [10:0] len, input logic pe,
                                input logic ce, input logic fe, input logic re);
      check_val({tag, "_pid"},    32'(PKT_RX_PID),    32'(pid));
      check_val({tag, "_len"},    32'(PKT_RX_LEN),    32'(len));
      check_val({tag, "_piderr"}, 32'(PKT_RX_PIDERR), 32'(pe));
      check_val({tag, "_crcerr"}, 32'(PKT_RX_CRCERR), 32'(ce));
      check_val({tag, "_fmterr"}, 32'(PKT_RX_FMTERR), 32'(fe));
      check_val({tag, "_rxerr"},  32'(PKT_RX_RXERR),  32'(re));
   endtask

   task automatic expect_all_zero(input string tag);
      check_val({tag, "_valid"}, 32'(PKT_RX_DAT_VALID), 32'd0);
      check_val({tag, "_dat"},   32'(PKT_RX_DAT),       32'd0);
      check_val({tag, "_done"},  32'(PKT_RX_DONE),      32'd0);
      expect_status(tag, 4'h0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Output monitor: compares every payload strobe and DONE with the model.
   always @(negedge ULPICLK) begin
      if (ULPIRSTB) begin
         if (PKT_RX_DAT_VALID) begin
            dat_seen++;
            if (exp_dat.size() == 0) check_val("dat_unexpected", 32'd1, 32'd0);
            else check_val("dat", 32'(PKT_RX_DAT), 32'(exp_dat.pop_front()));
         end
         if (PKT_RX_DONE) begin
            stat_t s;
            done_seen++;
            if (exp_done.size() == 0) check_val("done_unexpected", 32'd1, 32'd0);
            else begin
               s = exp_done.pop_front();
               check_val("done_pid",    32'(PKT_RX_PID),    32'(s.pid));
               check_val("done_len",    32'(PKT_RX_LEN),    32'(s.len));
               check_val("done_piderr", 32'(PKT_RX_PIDERR), 32'(s.pe));
               check_val("done_crcerr", 32'(PKT_RX_CRCERR), 32'(s.ce));
               check_val("done_fmterr", 32'(PKT_RX_FMTERR), 32'(s.fe));
               check_val("done_rxerr",  32'(PKT_RX_RXERR),  32'(s.re));
            end
         end
      end
   end

   initial begin
      int d0, n0;
      logic [7:0] pid_tab [0:7];
      pid_tab[0] = 8'hC3; pid_tab[1] = 8'h4B; pid_tab[2] = 8'h87; pid_tab[3] = 8'h0F;
      pid_tab[4] = 8'hD2; pid_tab[5] = 8'h5A; pid_tab[6] = 8'h1E; pid_tab[7] = 8'h96;
      model_reset();

      #12;
      expect_all_zero("reset");
      @(posedge ULPICLK); #1;
      ULPIRSTB = 1'b1;
      beat(1'b0, 1'b1, 8'hD2);           // data in IDLE is ignored
      beat(1'b0, 1'b0, 8'h00);

      // ACK, no payload
      d0 = done_seen; n0 = dat_seen;
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hD2); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      expect_status("ack", 4'h2, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("ack_done_count", 32'(done_seen - d0), 32'd1);
      check_val("ack_dat_count", 32'(dat_seen - n0), 32'd0);

      // DATA0, zero-length with correct CRC
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hC3);
      beat(1'b0, 1'b1, 8'h00); beat(1'b0, 1'b1, 8'h00); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      expect_status("data0_empty", 4'h3, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // DATA1, three bytes, wrong CRC
      n0 = dat_seen;
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'h4B);
      beat(1'b0, 1'b1, 8'hA1); beat(1'b0, 1'b1, 8'hA2); beat(1'b0, 1'b1, 8'hA3);
      beat(1'b0, 1'b1, 8'h00); beat(1'b0, 1'b1, 8'h00); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      expect_status("data1_bad", 4'hB, 11'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("data1_dat_count", 32'(dat_seen - n0), 32'd3);

      // Bad PID check nibble, data PID without bytes
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hD3); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      expect_status("piderr", 4'h3, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0);

      // RxError mid-packet
      d0 = done_seen; n0 = dat_seen;
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hC3); beat(1'b0, 1'b1, 8'h11);
      beat(1'b1, 1'b0, 8'h30); beat(1'b0, 1'b1, 8'h22); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      check_val("rxerr_flag", 32'(PKT_RX_RXERR), 32'd1);
      check_val("rxerr_done_count", 32'(done_seen - d0), 32'd1);
      check_val("rxerr_dat_count", 32'(dat_seen - n0), 32'd0);

      // Reset mid-packet, then a clean ACK
      d0 = done_seen;
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hC3); beat(1'b0, 1'b1, 8'h55);
      #2 ULPIRSTB = 1'b0;
      #2 expect_all_zero("mid_reset");
      @(posedge ULPICLK); #1;
      ULPIRSTB = 1'b1;
      model_reset();
      beat(1'b1, 1'b0, 8'h10); beat(1'b0, 1'b1, 8'hD2); beat(1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b0, 8'h00);
      expect_status("after_reset", 4'h2, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("after_reset_done_count", 32'(done_seen - d0), 32'd1);

      // Randomized packets
      for (int k = 0; k < 80; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            beat(1'b1, 1'b0, 8'h10); beat(1'b1, 1'b0, 8'h00);   // no PID byte
         end else if (r == 1) begin
            beat(1'b0, 1'b1, 8'($urandom));                     // stray data
         end else begin
            send_pkt((r == 2) ? 8'($urandom) : pid_tab[$urandom_range(0, 7)],
                     $urandom_range(0, 8), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1);
         end
      end

      // Long DATA0 packet: LEN saturation / babble
      send_pkt(8'hC3, 2100, 1'b1, 1'b0);
`ifndef SC_ULPI_URD_BABBLE_EN
      expect_status("long", 4'h3, 11'd2047, 1'b0, 1'b0, 1'b0, 1'b0);
`else
      check_val("babble_fmterr", 32'(PKT_RX_FMTERR), 32'd1);
`endif

      repeat (4) beat(1'b0, 1'b0, 8'h00);
      check_val("dat_pending", 32'(exp_dat.size()), 32'd0);
      check_val("done_pending", 32'(exp_done.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
